// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
// One bit per CALC cycle, sign fix-up and HI/LO write in FIX; MTHI/MTLO write directly from IDLE.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opd;
  logic               r_div;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_dz;
  logic               r_done;
  logic               r_divzero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_start_md;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed   = ~op[0];
  assign w_a_neg    = w_signed & a[WIDTH-1];
  assign w_b_neg    = w_signed & b[WIDTH-1];
  assign w_abs_a    = w_a_neg ? -a : a;
  assign w_abs_b    = w_b_neg ? -b : b;
  assign w_start_md = start & ~op[2];

  // Multiply: LSB-first shift-add, partial product grows down from the top half.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: restoring; upper half is the remainder, lower half shifts dividend out and quotient in.
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_opd});
  assign w_rem_sub = w_rem_sh - {1'b0, r_opd};
  assign w_div_acc = w_ge ? {w_rem_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                          : {w_rem_sh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0};

  assign w_prod = r_qneg ? -r_acc : r_acc;
  assign w_quo  = r_qneg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_rneg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_md) w_next = S_CALC;
      S_CALC: begin
        if (abort)                  w_next = S_IDLE;
        else if (r_cnt == CW'(1))   w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_CALC) || (r_state == S_FIX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opd     <= '0;
      r_div     <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz      <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_md) begin
            r_div  <= op[1];
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            r_dz   <= op[1] & (b == '0);
            r_cnt  <= CW'(WIDTH);
            if (op[1]) begin
              r_acc <= {{WIDTH{1'b0}}, w_abs_a};
              r_opd <= w_abs_b;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_abs_b};
              r_opd <= w_abs_a;
            end
          end else if (start && op == 3'b100) begin
            r_hi <= a;
          end else if (start && op == 3'b101) begin
            r_lo <= a;
          end
        end
        S_CALC: begin
          if (!abort) begin
            r_acc <= r_div ? w_div_acc : w_mul_acc;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (!abort) begin
            r_done <= 1'b1;
            if (r_div) begin
              r_hi      <= w_rem;
              r_lo      <= r_dz ? '1 : w_quo;
              r_divzero <= r_dz;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done    = r_done;
  assign divzero = r_divzero;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - directed self-checking bench for muldiv_hilo (WIDTH=32)
module tb_muldiv_hilo;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         abort = 1'b0;
  logic         busy, done, divzero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, scrambles operands after sampling, waits (bounded) for done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int cycles, output int busy_cnt, output bit got_done);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    cycles = 1; busy_cnt = 0;
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      tick();
      cycles++;
    end
    got_done = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL reset_divzero got %b want 0", divzero); end
    n_checks++; if (hi !== '0)        begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== '0)        begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int c, bc; bit d;
    run_op(3'b000, 32'hFFFF_FFFD, 32'd7, c, bc, d);
    n_checks++; if (d !== 1'b1) begin n_fail++; $display("FAIL mult_done got %b want 1", d); end
    n_checks++; if (c != 34)    begin n_fail++; $display("FAIL mult_latency got %0d want 34", c); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got %b want 0", done); end
  endtask

  task automatic test_multu();
    int c, bc; bit d;
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, bc, d);
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", lo); end
    n_checks++; if (bc != 33) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
  endtask

  task automatic test_div_seq();
    int c, bc; bit d;
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, c, bc, d);
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
    run_op(3'b011, 32'd7, 32'd0, c, bc, d);
    n_checks++; if (c != 34) begin n_fail++; $display("FAIL divz_latency got %0d want 34", c); end
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo got %h want ffffffff", lo); end
    n_checks++; if (hi !== 32'd7) begin n_fail++; $display("FAIL divz_hi got %h want 7", hi); end
    n_checks++; if (divzero !== 1'b1) begin n_fail++; $display("FAIL divz_flag got %b want 1", divzero); end
    // MULTU issued right after done must leave divzero set
    run_op(3'b001, 32'd9, 32'd11, c, bc, d);
    n_checks++; if (lo !== 32'd99) begin n_fail++; $display("FAIL b2b_multu_lo got %h want 63", lo); end
    n_checks++; if (divzero !== 1'b1) begin n_fail++; $display("FAIL mult_keeps_divzero got %b want 1", divzero); end
    run_op(3'b011, 32'd10, 32'd3, c, bc, d);
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo got %h want 3", lo); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_hi got %h want 1", hi); end
    n_checks++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL divu_clears_divzero got %b want 0", divzero); end
  endtask

  task automatic test_overflow();
    int c, bc; bit d;
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, c, bc, d);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_lo got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL ovf_hi got %h want 0", hi); end
    n_checks++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL ovf_divzero got %b want 0", divzero); end
    run_op(3'b010, 32'd7, 32'hFFFF_FFFE, c, bc, d);
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL div_negb_hi got %h want 1", hi); end
  endtask

  task automatic test_mthi_mtlo();
    int c; bit seen_done;
    seen_done = 1'b0;
    start = 1'b1; op = 3'b100; a = 32'd1234;
    tick();
    seen_done |= done;
    n_checks++; if (hi !== 32'd1234) begin n_fail++; $display("FAIL mthi got %h want 4d2", hi); end
    op = 3'b101; a = 32'd5678;
    tick();
    seen_done |= done;
    start = 1'b0;
    n_checks++; if (lo !== 32'd5678) begin n_fail++; $display("FAIL mtlo got %h want 162e", lo); end
    n_checks++; if (hi !== 32'd1234) begin n_fail++; $display("FAIL mtlo_keeps_hi got %h want 4d2", hi); end
    n_checks++; if (busy !== 1'b0 || seen_done) begin n_fail++; $display("FAIL mt_no_busy_done got busy=%b done_seen=%b want 0/0", busy, seen_done); end
    // MTHI while a MULT is running is ignored
    start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    c = 6;
    while (!done && c < 100) begin tick(); c++; end
    n_checks++; if (c != 34) begin n_fail++; $display("FAIL mt_ignored_latency got %0d want 34", c); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mt_ignored_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd30) begin n_fail++; $display("FAIL mt_ignored_lo got %h want 1e", lo); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mt_not_queued got busy=%b want 0", busy); end
  endtask

  task automatic test_abort();
    int c, bc; bit d; bit seen_done;
    run_op(3'b001, 32'h0001_0000, 32'h0001_0000, c, bc, d);
    n_checks++; if (hi !== 32'd1 || lo !== 32'd0) begin n_fail++; $display("FAIL abort_setup got %h_%h want 1_0", hi, lo); end
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd0;
    tick();
    start = 1'b0;
    repeat (9) tick();
    abort = 1'b1; start = 1'b1; op = 3'b100; a = 32'hBAD0_BAD0;
    tick();
    abort = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    seen_done = 1'b0;
    repeat (40) begin seen_done |= done; tick(); end
    n_checks++; if (seen_done) begin n_fail++; $display("FAIL abort_no_done got %b want 0", seen_done); end
    n_checks++; if (hi !== 32'd1 || lo !== 32'd0) begin n_fail++; $display("FAIL abort_hilo got %h_%h want 1_0", hi, lo); end
    n_checks++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL abort_divzero got %b want 0", divzero); end
    // abort in IDLE does not block an accepted start
    start = 1'b1; abort = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_idle got busy=%b want 1", busy); end
    c = 1;
    while (!done && c < 100) begin tick(); c++; end
    n_checks++; if (lo !== 32'd12 || !done) begin n_fail++; $display("FAIL abort_idle_result got lo=%h done=%b want c/1", lo, done); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = 3'b010; a = 32'd50; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_checks++; if (hi !== '0 || lo !== '0) begin n_fail++; $display("FAIL rst_mid_hilo got %h_%h want 0_0", hi, lo); end
    tick();
    reset = 1'b0;
    repeat (40) tick();
    n_checks++; if (done !== 1'b0 || hi !== '0 || lo !== '0) begin n_fail++; $display("FAIL rst_mid_no_result got done=%b %h_%h want 0 0_0", done, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div_seq();
    test_overflow();
    test_mthi_mtlo();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
